// File: rtl/interposer_pkg.sv
// Shared constants, control/request field positions and lane FSM encoding
// for the interposer lane arbiters.
package interposer_pkg;

  localparam int NODE_COUNT       = 8;
  localparam int NODE_COUNT_DIGIT = 3;
  localparam int REQ_W            = NODE_COUNT_DIGIT + 1;
  localparam int CTRL_W           = 3;

  localparam int REQ_VLD     = REQ_W - 1;
  localparam int REQ_DST_LSB = 0;

  localparam int CTRL_GRANT = 2;
  localparam int CTRL_RXEN  = 1;
  localparam int CTRL_BUSY  = 0;

  localparam logic [CTRL_W-1:0] CTRL_SRC_WORD  = 3'b101;
  localparam logic [CTRL_W-1:0] CTRL_DST_WORD  = 3'b011;
  localparam logic [CTRL_W-1:0] CTRL_BUSY_WORD = 3'b001;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    TURN  = 2'd2
  } arb_state_e;

endpackage

// File: rtl/lane_arbiter_if.sv
// Node-facing request/control bundle of one interposer lane.
// master = arbiter side, slave = node side.
interface lane_arbiter_if;
  logic [interposer_pkg::NODE_COUNT*interposer_pkg::REQ_W-1:0]  req_in;
  logic [interposer_pkg::NODE_COUNT*interposer_pkg::CTRL_W-1:0] ctrl_out;
  logic [interposer_pkg::NODE_COUNT_DIGIT-1:0]                  active_src;
  logic                                                         illegal_req;
  logic [15:0]                                                  grant_total;

  modport master (
    input  req_in,
    output ctrl_out, active_src, illegal_req, grant_total
  );

  modport slave (
    output req_in,
    input  ctrl_out, active_src, illegal_req, grant_total
  );
endinterface

// File: rtl/lane_arbiter_rr_picker.sv
// Combinational round-robin pick: first set bit of legal_i at or after ptr_i,
// wrapping; the doubled mask turns the wrap into a plain lowest-bit search.
module rr_picker
  import interposer_pkg::*;
(
  input  logic [NODE_COUNT-1:0]       legal_i,
  input  logic [NODE_COUNT_DIGIT-1:0] ptr_i,
  output logic                        any_hit_o,
  output logic [NODE_COUNT_DIGIT-1:0] win_o
);

  logic [2*NODE_COUNT-1:0] dbl;
  logic [2*NODE_COUNT-1:0] below_ptr;
  logic [2*NODE_COUNT-1:0] masked;

  always_comb begin
    dbl       = {legal_i, legal_i};
    below_ptr = ({{(2*NODE_COUNT-1){1'b0}}, 1'b1} << ptr_i) - 1'b1;
    masked    = dbl & ~below_ptr;
    any_hit_o = |legal_i;
    win_o     = '0;
    for (int i = 2*NODE_COUNT-1; i >= 0; i--) begin
      if (masked[i]) win_o = NODE_COUNT_DIGIT'(i % NODE_COUNT);
    end
  end

endmodule

// File: rtl/lane_arbiter.sv
// Round-robin arbiter for one directional interposer lane: grant, hold for
// HOLD_CYCLES, one turnaround cycle, then re-arbitrate. All outputs registered.
module lane_arbiter
  import interposer_pkg::*;
#(
  parameter int DIRECTION   = 0,
  parameter int HOLD_CYCLES = 1
) (
  input  logic           clk,
  input  logic           reset,
  lane_arbiter_if.master lane
);

  localparam int CW = NODE_COUNT * CTRL_W;

  logic [NODE_COUNT-1:0] valid;
  logic [NODE_COUNT-1:0] legal;

  for (genvar n = 0; n < NODE_COUNT; n++) begin : g_legal
    logic [NODE_COUNT_DIGIT-1:0] dst;
    assign dst      = lane.req_in[n*REQ_W + REQ_DST_LSB +: NODE_COUNT_DIGIT];
    assign valid[n] = lane.req_in[n*REQ_W + REQ_VLD];
    assign legal[n] = valid[n] && (int'(dst) < NODE_COUNT) &&
                      ((DIRECTION == 0) ? (int'(dst) > n) : (int'(dst) < n));
  end

  arb_state_e                  state_q, state_d;
  logic [NODE_COUNT_DIGIT-1:0] win_src_q, win_src_d;
  logic [NODE_COUNT_DIGIT-1:0] win_dst_q, win_dst_d;
  logic [NODE_COUNT_DIGIT-1:0] rr_ptr_q, rr_ptr_d;
  logic [NODE_COUNT_DIGIT-1:0] active_q, active_d;
  logic [3:0]                  hold_q, hold_d;
  logic [CW-1:0]               ctrl_q, ctrl_d;
  logic                        illegal_q, illegal_d;
  logic [15:0]                 total_q, total_d;

  logic                        any_hit;
  logic [NODE_COUNT_DIGIT-1:0] pick;

  rr_picker u_picker (
    .legal_i   (legal),
    .ptr_i     (rr_ptr_q),
    .any_hit_o (any_hit),
    .win_o     (pick)
  );

  always_comb begin
    state_d   = state_q;
    win_src_d = win_src_q;
    win_dst_d = win_dst_q;
    rr_ptr_d  = rr_ptr_q;
    active_d  = active_q;
    hold_d    = hold_q;
    total_d   = total_q;
    illegal_d = 1'b0;
    ctrl_d    = '0;

    unique case (state_q)
      IDLE: begin
        illegal_d = |(valid & ~legal);
        if (any_hit) begin
          win_src_d = pick;
          win_dst_d = lane.req_in[int'(pick)*REQ_W + REQ_DST_LSB +: NODE_COUNT_DIGIT];
          hold_d    = 4'(HOLD_CYCLES);
          state_d   = GRANT;
        end
      end
      GRANT: begin
        hold_d = hold_q - 4'd1;
        if (hold_q == 4'd1) state_d = TURN;
      end
      TURN: begin
        rr_ptr_d = (win_src_q == NODE_COUNT_DIGIT'(NODE_COUNT-1)) ? '0 : win_src_q + 1'b1;
        if (total_q != 16'hFFFF) total_d = total_q + 16'd1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Outputs are registered, so they are built from the state being entered.
    if (state_d == GRANT) begin
      active_d = win_src_d;
      for (int n = 0; n < NODE_COUNT; n++) begin
        if (NODE_COUNT_DIGIT'(n) == win_src_d)      ctrl_d[n*CTRL_W +: CTRL_W] = CTRL_SRC_WORD;
        else if (NODE_COUNT_DIGIT'(n) == win_dst_d) ctrl_d[n*CTRL_W +: CTRL_W] = CTRL_DST_WORD;
        else                                        ctrl_d[n*CTRL_W +: CTRL_W] = CTRL_BUSY_WORD;
      end
    end else if (state_d == TURN) begin
      for (int n = 0; n < NODE_COUNT; n++) ctrl_d[n*CTRL_W +: CTRL_W] = CTRL_BUSY_WORD;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      win_src_q <= '0;
      win_dst_q <= '0;
      rr_ptr_q  <= '0;
      active_q  <= '0;
      hold_q    <= '0;
      ctrl_q    <= '0;
      illegal_q <= 1'b0;
      total_q   <= '0;
    end else begin
      state_q   <= state_d;
      win_src_q <= win_src_d;
      win_dst_q <= win_dst_d;
      rr_ptr_q  <= rr_ptr_d;
      active_q  <= active_d;
      hold_q    <= hold_d;
      ctrl_q    <= ctrl_d;
      illegal_q <= illegal_d;
      total_q   <= total_d;
    end
  end

  assign lane.ctrl_out    = ctrl_q;
  assign lane.active_src  = active_q;
  assign lane.illegal_req = illegal_q;
  assign lane.grant_total = total_q;

endmodule
